apb_xfer_master: RTL and testbench

- Master-side APB sequencer of the x2p bridge.
- Accepts one request at a time from the upstream bus-side logic over a valid/ready command port.
- Drives the apb_package master_s_type bundle plus a one-hot psel vector, waits for pready, and returns the captured slave_s_type result on a valid/ready response port.
- Adds address decode and an access timeout, so an absent or hung peripheral cannot stall the bus.

---
 rtl/apb_xfer_master_if.sv | 37 +++
 rtl/apb_xfer_master.sv | 148 ++++++++++++++
 tb/tb_apb_xfer_master.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_xfer_master_if.sv
// Shared APB type bundle and the APB-side interface of the x2p bridge master sequencer.
package apb_package;
  localparam int DATA_LENGTH = 32;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] paddr;
    logic [2:0]             pprot;
    logic                   penable;
    logic                   pwrite;
    logic [DATA_LENGTH-1:0] pwdata;
    logic [3:0]             pstrb;
  } master_s_type;

  typedef struct packed {
    logic                   pready;
    logic [DATA_LENGTH-1:0] prdata;
    logic                   pslverr;
  } slave_s_type;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_DECERR  = 2'b10,
    RSP_TIMEOUT = 2'b11
  } rsp_err_e;
endpackage

interface apb_xfer_master_if #(
  parameter int NUM_SLAVES = 4
);
  apb_package::master_s_type apb_m_out;
  logic [NUM_SLAVES-1:0]     psel;
  apb_package::slave_s_type  apb_s_in;

  modport master (output apb_m_out, output psel, input apb_s_in);
  modport slave  (input apb_m_out, input psel, output apb_s_in);
endinterface

// File: rtl/apb_xfer_master.sv
// APB master sequencer: takes one command at a time, decodes the slave, runs SETUP/ACCESS
// with an access timeout, and returns read data plus a 2-bit status on a response port.
module apb_xfer_master
  import apb_package::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int DEC_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [DATA_LENGTH-1:0] req_addr,
  input  logic                   req_write,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  input  logic [3:0]             req_strb,
  input  logic [2:0]             req_prot,
  apb_xfer_master_if.master      apb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_LENGTH-1:0] rsp_rdata,
  output logic [1:0]             rsp_err
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e                 state_q,     state_d;
  master_s_type           m_q,         m_d;
  logic [NUM_SLAVES-1:0]  psel_q,      psel_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [DATA_LENGTH-1:0] rsp_rdata_q, rsp_rdata_d;
  rsp_err_e               rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]       cnt_q,       cnt_d;

  logic [IDX_W-1:0] req_idx;
  logic             idx_ok;

  assign req_idx = req_addr[DEC_LSB +: IDX_W];
  assign idx_ok  = (int'(req_idx) < NUM_SLAVES);

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a signal
    // unassigned; without these defaults synthesis would infer latches.
    state_d     = state_q;
    m_d         = m_q;
    psel_d      = psel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (idx_ok) begin
            state_d      = SETUP;
            m_d.paddr    = req_addr;
            m_d.pprot    = req_prot;
            m_d.penable  = 1'b0;
            m_d.pwrite   = req_write;
            // Reads carry no write data or strobes on the bus.
            m_d.pwdata   = req_write ? req_wdata : '0;
            m_d.pstrb    = req_write ? req_strb  : '0;
            psel_d       = NUM_SLAVES'(1) << req_idx;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = RSP_DECERR;
          end
        end
      end

      SETUP: begin
        m_d.penable = 1'b1;
        state_d     = ACCESS;
      end

      ACCESS: begin
        // pready takes priority over an expiring timeout in the same cycle.
        if (apb.apb_s_in.pready) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_q.pwrite ? '0 : apb.apb_s_in.prdata;
          rsp_err_d   = apb.apb_s_in.pslverr ? RSP_SLVERR : RSP_OK;
          m_d         = '0;
          psel_d      = '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = RSP_TIMEOUT;
          m_d         = '0;
          psel_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = RSP_OK;
          cnt_d       = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge value; the synchronous reset drops psel/penable on the edge it is seen.
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= '0;
      psel_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= RSP_OK;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      psel_q      <= psel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign apb.apb_m_out = m_q;
  assign apb.psel      = psel_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_apb_xfer_master.sv
// Scoreboard bench for apb_xfer_master: directed scenarios plus randomized traffic against
// a transaction-level model of decode, wait states, slave errors and the access timeout.
module tb_apb_xfer_master;
  import apb_package::*;

  localparam int NUM_SLAVES = 3;
  localparam int DEC_LSB    = 12;
  localparam int TIMEOUT    = 16;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [2:0]  psel;
    int          wait_n;
    logic        slverr;
    logic [31:0] prdata;
    int          n_access;
  } apb_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          first_cyc;
    int          hold;
  } rsp_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  apb_xfer_master_if #(.NUM_SLAVES(NUM_SLAVES)) apb_if ();

  apb_xfer_master #(
    .NUM_SLAVES    (NUM_SLAVES),
    .DEC_LSB       (DEC_LSB),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .req_write(req_write),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .req_prot (req_prot),
    .apb      (apb_if),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  apb_exp_t apb_q[$];
  rsp_exp_t rsp_q[$];
  logic     rsp_active = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave responder and APB protocol monitor.
  initial begin
    int       acc_n   = 0;
    int       setup_n = 0;
    apb_exp_t e;
    master_s_type em;
    apb_if.apb_s_in = '0;
    forever begin
      @(negedge clk);
      apb_if.apb_s_in.pready  = 1'($urandom_range(0, 1));
      apb_if.apb_s_in.prdata  = $urandom;
      apb_if.apb_s_in.pslverr = 1'($urandom_range(0, 1));
      if (rst) begin
        acc_n   = 0;
        setup_n = 0;
      end else if (apb_if.psel != '0) begin
        check("psel_onehot", 128'($onehot(apb_if.psel)), 128'(1));
        if (apb_q.size() == 0) begin
          check("psel_unexpected", 128'(apb_if.psel), 128'(0));
        end else begin
          e            = apb_q[0];
          em.paddr     = e.addr;
          em.pprot     = e.prot;
          em.pwrite    = e.write;
          em.pwdata    = e.write ? e.wdata : 32'h0;
          em.pstrb     = e.write ? e.strb  : 4'h0;
          em.penable   = (setup_n != 0);
          if (setup_n == 0) begin
            check("apb_setup", {apb_if.psel, apb_if.apb_m_out}, {e.psel, em});
            setup_n = 1;
          end else begin
            check("apb_access", {apb_if.psel, apb_if.apb_m_out}, {e.psel, em});
            apb_if.apb_s_in.pready = (acc_n == e.wait_n);
            if (apb_if.apb_s_in.pready) begin
              apb_if.apb_s_in.prdata  = e.prdata;
              apb_if.apb_s_in.pslverr = e.slverr;
            end
            acc_n++;
          end
        end
      end else begin
        check("penable_without_psel", 128'(apb_if.apb_m_out.penable), 128'(0));
        if (setup_n != 0) begin
          check("apb_access_cycles", 128'(acc_n), 128'(apb_q[0].n_access));
          void'(apb_q.pop_front());
          acc_n   = 0;
          setup_n = 0;
        end
      end
    end
  end

  // Response scoreboard: pops an expectation when a response appears and drives rsp_ready.
  initial begin
    rsp_exp_t cur;
    int       rsp_idx = 0;
    logic     post_hs = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_active = 1'b0;
        post_hs    = 1'b0;
        rsp_ready  = 1'b0;
      end else begin
        if (post_hs) begin
          check("req_ready_after_rsp", 128'(req_ready), 128'(1));
          check("rsp_valid_after_rsp", 128'(rsp_valid), 128'(0));
          post_hs = 1'b0;
        end
        if (rsp_valid) begin
          if (!rsp_active) begin
            if (rsp_q.size() == 0) begin
              check("rsp_unexpected", 128'(rsp_valid), 128'(0));
              rsp_ready = 1'b1;
            end else begin
              cur        = rsp_q.pop_front();
              rsp_active = 1'b1;
              rsp_idx    = 0;
              check("rsp_latency", 128'(cyc), 128'(cur.first_cyc));
            end
          end
          if (rsp_active) begin
            check("rsp_rdata", 128'(rsp_rdata), 128'(cur.rdata));
            check("rsp_err", 128'(rsp_err), 128'(cur.err));
            rsp_ready = (rsp_idx == cur.hold);
            if (rsp_ready) begin
              rsp_active = 1'b0;
              post_hs    = 1'b1;
            end
            rsp_idx++;
          end
        end else begin
          if (rsp_active) check("rsp_valid_dropped", 128'(rsp_valid), 128'(1));
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Issues one command and records what the spec says must happen on the bus and response port.
  task automatic issue(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                       input logic slverr, input logic [31:0] prdata, input int hold);
    logic [31:0] a = addr;
    logic [1:0]  idx = a[DEC_LSB +: 2];
    logic        dec_err = (int'(idx) >= NUM_SLAVES);
    int          n_acc = (wait_n + 1 > TIMEOUT) ? TIMEOUT : wait_n + 1;
    int          guard = 0;
    apb_exp_t    ae;
    rsp_exp_t    re;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    req_write = write;
    req_wdata = wdata;
    req_strb  = strb;
    req_prot  = prot;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("req_accept_timeout", 128'(req_ready), 128'(1));
      req_valid = 1'b0;
      return;
    end
    re.hold = hold;
    if (dec_err) begin
      re.rdata     = 32'h0;
      re.err       = 2'b10;
      re.first_cyc = cyc + 1;
    end else begin
      re.first_cyc = cyc + 1 + n_acc + 1;
      if (wait_n >= TIMEOUT) begin
        re.rdata = 32'h0;
        re.err   = 2'b11;
      end else begin
        re.rdata = write ? 32'h0 : prdata;
        re.err   = slverr ? 2'b01 : 2'b00;
      end
      ae.addr     = addr;
      ae.write    = write;
      ae.wdata    = wdata;
      ae.strb     = strb;
      ae.prot     = prot;
      ae.psel     = 3'b001 << idx;
      ae.wait_n   = wait_n;
      ae.slverr   = slverr;
      ae.prdata   = prdata;
      ae.n_access = n_acc;
      apb_q.push_back(ae);
    end
    rsp_q.push_back(re);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_write = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    req_strb  = 4'($urandom);
    req_prot  = 3'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while ((rsp_q.size() != 0 || rsp_active || apb_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", 128'(guard < 300), 128'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_strb  = '0;
    req_prot  = '0;
    repeat (3) @(negedge clk);
    check("reset_psel", 128'(apb_if.psel), 128'(0));
    check("reset_m_out", 128'(apb_if.apb_m_out), 128'(0));
    check("reset_rsp", {rsp_valid, rsp_rdata, rsp_err}, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 128'(req_ready), 128'(1));

    // Zero-wait write to slave 2.
    issue(32'h0000_2010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'h2, 0, 1'b0, 32'h0, 0);
    drain();
    // Read from slave 1 with two wait states.
    issue(32'h0000_1004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'h0, 2, 1'b0, 32'h1234_5678, 1);
    drain();
    // Slave error on a write, response held three cycles before the handshake.
    issue(32'h0000_0100, 1'b1, 32'hCAFE_F00D, 4'h3, 3'h1, 0, 1'b1, 32'h5555_AAAA, 3);
    drain();
    // Decode error: index 3 with only three slaves.
    issue(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'h0, 0, 1'b0, 32'h0, 0);
    drain();
    // Stuck slave times out; pready on the last permitted ACCESS cycle still wins.
    issue(32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'h4, 1000, 1'b0, 32'h0, 0);
    drain();
    issue(32'h0000_1000, 1'b0, 32'h0, 4'h0, 3'h4, TIMEOUT - 1, 1'b0, 32'h0BAD_F00D, 0);
    drain();

    // Reset in the middle of a wait-stated read.
    issue(32'h0000_1008, 1'b0, 32'h0, 4'h0, 3'h0, 10, 1'b0, 32'h7777_7777, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_psel", 128'(apb_if.psel), 128'(0));
    check("abort_m_out", 128'(apb_if.apb_m_out), 128'(0));
    check("abort_rsp", {rsp_valid, rsp_rdata, rsp_err}, 128'(0));
    apb_q.delete();
    rsp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_req_ready", 128'(req_ready), 128'(1));
    issue(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'h0, 1, 1'b0, 32'h600D_DA7A, 0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] addr = $urandom;
      int          sel  = $urandom_range(0, 9);
      int          w;
      addr[DEC_LSB +: 2] = (sel == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: w = $urandom_range(0, 3);
        6, 7:             w = $urandom_range(TIMEOUT - 3, TIMEOUT + 1);
        default:          w = 0;
      endcase
      issue(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), 3'($urandom),
            w, 1'($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
